// File: rtl/motion_update_broadcaster_pkg.sv
// motion_update_broadcaster_pkg: cell geometry, FSM states and cell-ID packing shared by the broadcaster
package motion_update_broadcaster_pkg;

  localparam int CELL_ID_WIDTH  = 4;
  localparam int X_CELL_NUM     = 4;
  localparam int Y_CELL_NUM     = 4;
  localparam int Z_CELL_NUM     = 4;
  localparam int POS_CELL_LSB   = 24;
  localparam int CELL_SEL_WIDTH = 3 * CELL_ID_WIDTH;

  typedef enum logic [3:0] {
    IDLE,
    EN_LEAD,
    RD_CNT,
    WAIT_CNT,
    STREAM,
    DRAIN,
    NEXT_CELL,
    EN_TAIL,
    GAP,
    DONE
  } mu_state_t;

  // Cell IDs travel as {x,y,z}, each 1-based
  function automatic logic [CELL_SEL_WIDTH-1:0] cell_id(
    input logic [CELL_ID_WIDTH-1:0] x,
    input logic [CELL_ID_WIDTH-1:0] y,
    input logic [CELL_ID_WIDTH-1:0] z
  );
    return {x, y, z};
  endfunction

endpackage

// File: rtl/motion_update_broadcaster_dst_cell_calc.sv
// motion_update_broadcaster_dst_cell_calc: one position component moved by its displacement, wrapped into the box, and its 1-based cell index
module motion_update_broadcaster_dst_cell_calc #(
  parameter int DATA_WIDTH    = 32,
  parameter int CELL_ID_WIDTH = 4,
  parameter int POS_CELL_LSB  = 24,
  parameter int CELL_NUM      = 4
) (
  input  logic [DATA_WIDTH-1:0]    i_pos,
  input  logic [DATA_WIDTH-1:0]    i_disp,
  output logic [DATA_WIDTH-1:0]    o_pos,
  output logic [CELL_ID_WIDTH-1:0] o_dst
);

  logic [DATA_WIDTH-1:0]    w_sum;
  logic [CELL_ID_WIDTH-1:0] w_cell;
  logic                     w_wrap;

  // Displacements are small, so a single subtraction of one box length is enough to wrap
  assign w_sum  = i_pos + i_disp;
  assign w_cell = w_sum[POS_CELL_LSB +: CELL_ID_WIDTH];
  assign w_wrap = w_cell >= CELL_ID_WIDTH'(CELL_NUM);
  assign o_pos  = w_wrap ? w_sum - (DATA_WIDTH'(CELL_NUM) << POS_CELL_LSB) : w_sum;
  assign o_dst  = (w_wrap ? w_cell - CELL_ID_WIDTH'(CELL_NUM) : w_cell) + 1'b1;

endmodule

// File: rtl/motion_update_broadcaster.sv
// motion_update_broadcaster: walks every cell's position buffer, moves each particle and broadcasts it with its destination cell
// Optional MU_BCAST_STATS_EN adds out_migrated_cnt, the number of particles leaving their source cell in the last pass.
module motion_update_broadcaster
  import motion_update_broadcaster_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [CELL_SEL_WIDTH-1:0] out_rd_cell_sel,
  output logic [ADDR_WIDTH-1:0]     out_rd_address,
  output logic                      out_rden,
  input  logic [3*DATA_WIDTH-1:0]   in_pos,
  input  logic [3*DATA_WIDTH-1:0]   in_disp,
  output logic                      out_motion_update_enable,
  output logic [3*DATA_WIDTH-1:0]   out_data,
  output logic [CELL_SEL_WIDTH-1:0] out_data_dst_cell,
  output logic                      out_data_valid,
  output logic                      count_overflow
`ifdef MU_BCAST_STATS_EN
  ,
  output logic [15:0]               out_migrated_cnt
`endif
);

  localparam int CW = CELL_ID_WIDTH;

  mu_state_t                 r_state, w_next;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [ADDR_WIDTH-1:0]     r_cnt;
  logic [1:0]                r_tmr;
  logic                      r_pend;
  logic [CW-1:0]             r_x, r_y, r_z;
  logic [ADDR_WIDTH-1:0]     w_cnt_raw;
  logic                      w_over;
  logic                      w_last_cell;
  logic [3*DATA_WIDTH-1:0]   w_data;
  logic [CELL_SEL_WIDTH-1:0] w_dst;

  assign w_cnt_raw       = in_pos[ADDR_WIDTH-1:0];
  assign w_over          = w_cnt_raw > ADDR_WIDTH'(PARTICLE_NUM);
  assign out_rd_cell_sel = cell_id(r_x, r_y, r_z);
  assign w_last_cell     = out_rd_cell_sel == cell_id(CW'(X_CELL_NUM), CW'(Y_CELL_NUM), CW'(Z_CELL_NUM));

  // Component 0 is x (low bits of the data word); dst cell is packed {x,y,z} so x lands in the top field
  for (genvar g = 0; g < 3; g++) begin : g_comp
    motion_update_broadcaster_dst_cell_calc #(
      .DATA_WIDTH   (DATA_WIDTH),
      .CELL_ID_WIDTH(CW),
      .POS_CELL_LSB (POS_CELL_LSB),
      .CELL_NUM     (g == 0 ? X_CELL_NUM : g == 1 ? Y_CELL_NUM : Z_CELL_NUM)
    ) u_calc (
      .i_pos (in_pos[g*DATA_WIDTH +: DATA_WIDTH]),
      .i_disp(in_disp[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_pos (w_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_dst (w_dst[(2-g)*CW +: CW])
    );
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // Next-state and Moore outputs; enable brackets the whole walk, then drops for the gap
  always_comb begin
    w_next                   = r_state;
    busy                     = r_state != IDLE;
    done                     = 1'b0;
    out_rden                 = 1'b0;
    out_rd_address           = '0;
    out_motion_update_enable = 1'b0;
    case (r_state)
      IDLE:      w_next = start ? EN_LEAD : IDLE;
      EN_LEAD: begin
        out_motion_update_enable = 1'b1;
        w_next                   = RD_CNT;
      end
      RD_CNT: begin
        out_motion_update_enable = 1'b1;
        out_rden                 = 1'b1;
        w_next                   = WAIT_CNT;
      end
      WAIT_CNT: begin
        out_motion_update_enable = 1'b1;
        w_next                   = w_cnt_raw == '0 ? NEXT_CELL : STREAM;
      end
      STREAM: begin
        out_motion_update_enable = 1'b1;
        out_rden                 = 1'b1;
        out_rd_address           = r_addr;
        w_next                   = r_addr == r_cnt ? DRAIN : STREAM;
      end
      DRAIN: begin
        out_motion_update_enable = 1'b1;
        w_next                   = r_tmr == 2'd1 ? NEXT_CELL : DRAIN;
      end
      NEXT_CELL: begin
        out_motion_update_enable = 1'b1;
        w_next                   = w_last_cell ? EN_TAIL : RD_CNT;
      end
      EN_TAIL: begin
        out_motion_update_enable = 1'b1;
        w_next                   = GAP;
      end
      GAP:       w_next = r_tmr == 2'd2 ? DONE : GAP;
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default:   w_next = IDLE;
    endcase
  end

  // Particle count latch, address counter, dwell timer and the in-flight read flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr         <= '0;
      r_cnt          <= '0;
      r_tmr          <= '0;
      r_pend         <= 1'b0;
      count_overflow <= 1'b0;
    end else begin
      r_tmr  <= w_next == r_state ? r_tmr + 1'b1 : 2'd0;
      r_pend <= r_state == STREAM;
      if (r_state == WAIT_CNT) begin
        r_addr         <= ADDR_WIDTH'(1);
        r_cnt          <= w_over ? ADDR_WIDTH'(PARTICLE_NUM) : w_cnt_raw;
        count_overflow <= count_overflow | w_over;
      end else if (r_state == STREAM) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  // Cell walk with z fastest; the last increment rolls back to {1,1,1} ready for the next pass
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x <= CW'(1);
      r_y <= CW'(1);
      r_z <= CW'(1);
    end else if (r_state == NEXT_CELL) begin
      r_z <= r_z == CW'(Z_CELL_NUM) ? CW'(1) : r_z + 1'b1;
      if (r_z == CW'(Z_CELL_NUM)) begin
        r_y <= r_y == CW'(Y_CELL_NUM) ? CW'(1) : r_y + 1'b1;
        if (r_y == CW'(Y_CELL_NUM)) r_x <= r_x == CW'(X_CELL_NUM) ? CW'(1) : r_x + 1'b1;
      end
    end
  end

  // Broadcast register: one cycle behind the memory readout, zeroed whenever no particle is carried
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data          <= '0;
      out_data_dst_cell <= '0;
      out_data_valid    <= 1'b0;
    end else begin
      out_data          <= r_pend ? w_data : '0;
      out_data_dst_cell <= r_pend ? w_dst : '0;
      out_data_valid    <= r_pend;
    end
  end

`ifdef MU_BCAST_STATS_EN
  // Migration counter; the source cell cannot change while a read is in flight, so out_rd_cell_sel is the source
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                     out_migrated_cnt <= '0;
    else if (r_state == IDLE && start)            out_migrated_cnt <= '0;
    else if (r_pend && w_dst != out_rd_cell_sel && out_migrated_cnt != 16'hFFFF)
                                                  out_migrated_cnt <= out_migrated_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_motion_update_broadcaster.sv
// tb_motion_update_broadcaster: directed passes through a cell-memory model, with a queue scoreboard on the broadcast bus
module tb_motion_update_broadcaster;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         busy, done, out_rden, out_motion_update_enable, out_data_valid, count_overflow;
  logic [11:0]  out_rd_cell_sel, out_data_dst_cell;
  logic [7:0]   out_rd_address;
  logic [95:0]  in_pos = '0;
  logic [95:0]  in_disp = '0;
  logic [95:0]  out_data;
`ifdef MU_BCAST_STATS_EN
  logic [15:0]  out_migrated_cnt;
`endif

  logic [95:0]  pos_mem  [0:63][0:255];
  logic [95:0]  disp_mem [0:63][0:255];
  logic [107:0] sb[$];
  int           n_cmp = 0;
  int           n_err = 0;

  motion_update_broadcaster dut (
    .clk                     (clk),
    .rst                     (rst),
    .start                   (start),
    .busy                    (busy),
    .done                    (done),
    .out_rd_cell_sel         (out_rd_cell_sel),
    .out_rd_address          (out_rd_address),
    .out_rden                (out_rden),
    .in_pos                  (in_pos),
    .in_disp                 (in_disp),
    .out_motion_update_enable(out_motion_update_enable),
    .out_data                (out_data),
    .out_data_dst_cell       (out_data_dst_cell),
    .out_data_valid          (out_data_valid),
    .count_overflow          (count_overflow)
`ifdef MU_BCAST_STATS_EN
    ,
    .out_migrated_cnt        (out_migrated_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic int cidx(input logic [11:0] s);
    return (int'(s[11:8]) - 1) * 16 + (int'(s[7:4]) - 1) * 4 + int'(s[3:0]) - 1;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void push(input logic [95:0] d, input logic [11:0] c);
    sb.push_back({c, d});
  endfunction

  task automatic clear_mem();
    for (int c = 0; c < 64; c++)
      for (int a = 0; a < 256; a++) begin
        pos_mem[c][a]  = '0;
        disp_mem[c][a] = '0;
      end
  endtask

  // Cell memory: registered readout one cycle after the address
  always @(posedge clk) if (out_rden) begin
    in_pos  <= pos_mem[cidx(out_rd_cell_sel)][out_rd_address];
    in_disp <= disp_mem[cidx(out_rd_cell_sel)][out_rd_address];
  end

  // Scoreboard monitor
  always @(negedge clk) if (rst) begin
    if (out_data_valid) begin
      chk("valid_inside_enable", out_motion_update_enable, 1);
      chk("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        logic [107:0] e;
        e = sb.pop_front();
        chk("out_data", out_data, e[95:0]);
        chk("out_dst_cell", out_data_dst_cell, e[107:96]);
      end
    end else if (out_motion_update_enable) begin
      chk("idle_bus_zero", {out_data, out_data_dst_cell}, 0);
    end
  end

  task automatic run_pass(input string nm, input int exp_en, input bit poke);
    int en = 0, cyc = 0, a1 = -1, v1 = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({nm, "_accepted"}, busy, 1);
    while (!done && cyc < 5000) begin
      if (out_motion_update_enable) en++;
      if (out_rden && out_rd_address == 8'd1 && a1 < 0) a1 = cyc;
      if (out_data_valid && v1 < 0) v1 = cyc;
      start = poke && cyc == 20;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({nm, "_done"}, done, 1);
    chk({nm, "_busy_at_done"}, busy, 1);
    chk({nm, "_enable_cycles"}, en, exp_en);
    if (a1 >= 0) chk({nm, "_valid_latency"}, v1 - a1, 2);
    else chk({nm, "_no_valid"}, v1 < 0, 1);
    chk({nm, "_sb_drained"}, sb.size(), 0);
  endtask

  task automatic load_overflow();
    clear_mem();
    pos_mem[24][0] = 96'd250;
    for (int i = 1; i <= 250; i++) begin
      pos_mem[24][i] = {32'(i), 32'h02000000 + 32'(i), 32'h01000000 + 32'(i)};
      if (i <= 220) push(pos_mem[24][i], 12'h231);
    end
    pos_mem[63][0]  = 96'd1;
    pos_mem[63][1]  = {32'h0F000000, 32'h03800000, 32'h03000000};
    disp_mem[63][1] = {32'h00000000, 32'h00900000, 32'h00000001};
    push({32'h0B000000, 32'h00100000, 32'h03000001}, 12'h41C);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic seen;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {busy, done, out_rden, out_rd_address, out_motion_update_enable, out_data_valid, count_overflow}, 0);
    chk("rst_bus", {out_data, out_data_dst_cell}, 0);
    chk("rst_cell_sel", out_rd_cell_sel, 12'h111);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_pass("zero", 1 + 64 * 3 + 1, 1'b0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | done | busy;
    end
    chk("zero_single_done", seen, 0);

    pos_mem[0][0]  = 96'd2;
    pos_mem[0][1]  = {32'h00000000, 32'h00100000, 32'h01000000};
    disp_mem[0][1] = {32'h00000000, 32'h00000000, 32'h00800000};
    pos_mem[0][2]  = {32'h00000005, 32'h00100000, 32'h03FF0000};
    disp_mem[0][2] = {32'hFFFFFFFF, 32'h00000000, 32'h00020000};
    push({32'h00000000, 32'h00100000, 32'h01800000}, 12'h211);
    push({32'h00000004, 32'h00100000, 32'h00010000}, 12'h111);
    run_pass("two", 1 + 7 + 63 * 3 + 1, 1'b0);
    chk("two_no_overflow", count_overflow, 0);
`ifdef MU_BCAST_STATS_EN
    chk("two_migrated", out_migrated_cnt, 1);
`endif

    load_overflow();
    run_pass("ovf", 1 + 225 + 6 + 62 * 3 + 1, 1'b1);
    chk("ovf_flag", count_overflow, 1);
`ifdef MU_BCAST_STATS_EN
    chk("ovf_migrated", out_migrated_cnt, 1);
`endif

    load_overflow();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (!(out_rden && out_rd_address == 8'd5) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached_addr5", out_rd_address, 5);
    #1 rst = 1'b0;
    #1;
    chk("abort_ctrl_async", {busy, done, out_rden, out_rd_address, out_motion_update_enable, out_data_valid, count_overflow}, 0);
    chk("abort_bus_async", {out_data, out_data_dst_cell}, 0);
    chk("abort_cell_sel", out_rd_cell_sel, 12'h111);
    @(negedge clk);
    chk("abort_ctrl_next", {busy, done, out_data_valid, out_motion_update_enable}, 0);
    sb.delete();
    rst = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | done | busy;
    end
    chk("abort_no_done", seen, 0);

    load_overflow();
    run_pass("restart", 1 + 225 + 6 + 62 * 3 + 1, 1'b0);
    chk("restart_flag", count_overflow, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
